// File: rtl/count_event_monitor.sv
// count_event_monitor
//   Watches the up/down counter output qd every cycle and classifies each
//   transition against the value captured on the previous edge. A detected
//   event is timestamped and pushed into a small show-ahead FIFO. A consumer
//   drains the FIFO over a valid/ready handshake.
//
// Ports
//   clk        rising-edge clock, shared with the counter stage
//   clear      asynchronous active-low reset
//   enable     monitoring enable (detection only; FIFO drain is unaffected)
//   qd         counter value being observed
//   thr_hi     high threshold (upward crossing is reported)
//   thr_lo     low threshold (downward crossing is reported)
//   evt_valid  head entry valid
//   evt_ready  consumer accepts the head entry
//   evt_code   head entry event type (1..5)
//   evt_value  head entry qd value
//   evt_time   head entry timestamp
//   fifo_level FIFO occupancy
//   drop_cnt   saturating count of events lost to a full FIFO
//
// Handshake: evt_valid is high whenever the FIFO holds at least one entry.
// The head entry is transferred on every rising edge where evt_valid and
// evt_ready are both high. While evt_valid=1 and evt_ready=0 the evt_*
// outputs hold their value. evt_valid does not depend on evt_ready.

module count_event_monitor #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TS_WIDTH   = 16
) (
  input  logic                        clk,
  input  logic                        clear,
  input  logic                        enable,
  input  logic [DATA_WIDTH-1:0]       qd,
  input  logic [DATA_WIDTH-1:0]       thr_hi,
  input  logic [DATA_WIDTH-1:0]       thr_lo,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [2:0]                  evt_code,
  output logic [DATA_WIDTH-1:0]       evt_value,
  output logic [TS_WIDTH-1:0]         evt_time,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [7:0]                  drop_cnt
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int LVL_W   = PTR_W + 1;
  localparam int ENTRY_W = 3 + DATA_WIDTH + TS_WIDTH;

  localparam logic [DATA_WIDTH-1:0] MAX_V   = '1;
  localparam logic [LVL_W-1:0]      DEPTH_L = LVL_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    EV_NONE     = 3'd0,
    EV_WRAP_UP  = 3'd1,
    EV_WRAP_DN  = 3'd2,
    EV_CROSS_HI = 3'd3,
    EV_CROSS_LO = 3'd4,
    EV_JUMP     = 3'd5
  } evt_code_e;

  logic [TS_WIDTH-1:0]   ts;
  logic [DATA_WIDTH-1:0] prev;
  logic                  primed;

  logic [DATA_WIDTH:0]   step_mag;
  logic [2:0]            det_code;
  logic                  push_req;
  logic                  push_ok;
  logic                  pop;
  logic                  drop;

  logic [ENTRY_W-1:0]    mem [FIFO_DEPTH];
  logic [ENTRY_W-1:0]    head;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic [LVL_W-1:0]      level;

  // Timestamp, previous sample and primed flag. primed lags enable by one
  // edge so the first enabled cycle compares against a stale prev and must
  // stay silent.
  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      ts     <= '0;
      prev   <= '0;
      primed <= 1'b0;
    end else begin
      ts     <= ts + TS_WIDTH'(1);
      prev   <= qd;
      primed <= enable;
    end
  end

  // Unsigned step magnitude, one bit wider than the data.
  always_comb begin
    step_mag = '0;
    if (qd >= prev) step_mag = {1'b0, qd} - {1'b0, prev};
    else            step_mag = {1'b0, prev} - {1'b0, qd};
  end

  // Classification; the if/else chain gives first-match priority.
  always_comb begin
    det_code = EV_NONE;
    if (enable && primed) begin
      if (prev == MAX_V && qd == '0)              det_code = EV_WRAP_UP;
      else if (prev == '0 && qd == MAX_V)         det_code = EV_WRAP_DN;
      else if (prev < thr_hi && qd >= thr_hi)     det_code = EV_CROSS_HI;
      else if (prev > thr_lo && qd <= thr_lo)     det_code = EV_CROSS_LO;
      else if (step_mag > (DATA_WIDTH+1)'(1))     det_code = EV_JUMP;
      else                                        det_code = EV_NONE;
    end
  end

  // A full FIFO still accepts a push when the head leaves on the same edge.
  // An empty FIFO never pops, so a push into it is held for at least a cycle.
  assign push_req = (det_code != EV_NONE);
  assign pop      = (level != '0) && evt_ready;
  assign push_ok  = push_req && ((level < DEPTH_L) || pop);
  assign drop     = push_req && !push_ok;

  // Storage needs no reset: the outputs are masked while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= {det_code, qd, ts};
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      drop_cnt <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push_ok, pop})
        2'b10:   level <= level + LVL_W'(1);
        2'b01:   level <= level - LVL_W'(1);
        default: level <= level;
      endcase
      if (drop && drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 8'd1;
    end
  end

  assign head       = mem[rd_ptr];
  assign evt_valid  = (level != '0);
  assign fifo_level = level;

  always_comb begin
    {evt_code, evt_value, evt_time} = '0;
    if (evt_valid) {evt_code, evt_value, evt_time} = head;
  end

endmodule

// File: doc/count_event_monitor.md
Name: count_event_monitor

Overview:
Downstream observer of the up/down counter stage. Samples the counter output qd every cycle and classifies transitions: wrap-up, wrap-down, high/low threshold crossings and load jumps. Each event is timestamped and buffered in a small FIFO. Events drain to the status/interrupt logic over a valid/ready handshake.

Parameters:
DATA_WIDTH, 8, width of the observed counter value qd
FIFO_DEPTH, 4, event FIFO entries; must be a power of 2, minimum 2
TS_WIDTH, 16, width of the free-running timestamp counter

Ports:
clk  in  1  rising-edge clock, shared with the counter stage
clear  in  1  asynchronous active-low reset
enable  in  1  monitoring enable
qd  in  DATA_WIDTH  counter value from the counter stage
thr_hi  in  DATA_WIDTH  high threshold
thr_lo  in  DATA_WIDTH  low threshold
evt_valid  out  1  FIFO head entry valid
evt_ready  in  1  consumer accepts the head entry
evt_code  out  3  event type of the head entry
evt_value  out  DATA_WIDTH  qd value that caused the event
evt_time  out  TS_WIDTH  timestamp at detection
fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
drop_cnt  out  8  events lost to a full FIFO; saturating

Behaviour:
- Reset (clear=0, async): all of the following clear immediately, regardless of clk.
  - evt_valid, fifo_level, drop_cnt, timestamp, primed flag, prev register all go to 0.
  - evt_code, evt_value and evt_time go to 0.
  - Reset mid-operation discards all FIFO contents.
- Timestamp: increments every cycle after reset and wraps modulo 2^TS_WIDTH. It does not depend on enable.
- Sampling:
  - prev <= qd on every rising edge.
  - primed <= enable on every rising edge.
  - Detection runs only when enable=1 and primed=1. The first cycle after enable rises is therefore event-free.
- Classification, MAX = 2^DATA_WIDTH-1. At most one event per cycle, first match wins:
  - code 1 WRAP_UP: prev==MAX and qd==0
  - code 2 WRAP_DN: prev==0 and qd==MAX
  - code 3 CROSS_HI: prev<thr_hi and qd>=thr_hi
  - code 4 CROSS_LO: prev>thr_lo and qd<=thr_lo
  - code 5 JUMP: |qd-prev|>1, computed unsigned with DATA_WIDTH+1 bits
  - otherwise no event (steps of 0 or ±1 without a crossing)
  - Codes 0, 6 and 7 are never produced.
- Latency:
  - Detection is combinational on qd vs prev; the entry is written at the same edge that captures qd into prev.
  - evt_valid is therefore high in the cycle after qd takes the event value: 1 cycle of latency.
  - Pushed entry = {code, qd, current timestamp}.
- FIFO:
  - Show-ahead; the evt_* outputs always reflect the head entry.
  - evt_valid = (fifo_level != 0).
  - A pop occurs on an edge where evt_valid && evt_ready.
  - evt_* must stay stable while evt_valid=1 and evt_ready=0.
- Full FIFO:
  - A push is accepted when level<FIFO_DEPTH, or when the FIFO is full and a pop happens on the same edge.
  - Otherwise the event is dropped, drop_cnt increments, and drop_cnt saturates at 255.
- Simultaneous push and pop on a non-empty FIFO: level is unchanged.
- Empty FIFO with a push: evt_valid rises next cycle. A push into an empty FIFO cannot be popped on the same edge.
- Pointers wrap modulo FIFO_DEPTH.
- Enable low:
  - No new events are detected.
  - FIFO draining continues normally.
  - Stored entries are kept.
- Threshold changes take effect the same cycle. thr_hi<thr_lo is legal, with no special handling.

Test Plan:
1. Wrap-up: enable=1, qd 253,254,255,0, thr_hi=200, thr_lo=10, evt_ready=1 -> exactly one entry {1,0,t}. evt_valid pulses one cycle, starting the cycle after qd=0.
2. Threshold crossing: qd counts up 98..102 with thr_hi=100, then down 12..8 with thr_lo=10 -> entries {3,100} then {4,10}, in order, with increasing timestamps.
3. Load jump and priority:
   - qd 5 -> 200 with thr_hi=100 -> {3,200}, since CROSS_HI beats JUMP.
   - qd 200 -> 150 -> {5,150}.
   - qd 0 -> 255 -> {2,255}.
4. Back-pressure and overflow: evt_ready=0, generate 6 events with FIFO_DEPTH=4 -> fifo_level=4, drop_cnt=2, head stable. Then assert evt_ready for 4 cycles -> first 4 events out in order, evt_valid=0.
5. Full with simultaneous push/pop: FIFO full, evt_ready=1 on the same edge a new event occurs -> no drop, level stays 4, drop_cnt unchanged.
6. Enable and reset:
   - enable rises while qd steps 255 -> 0 on the first enabled edge -> no event (not primed).
   - Assert clear asynchronously mid-burst with 3 entries -> evt_valid, fifo_level, drop_cnt and timestamp read 0 before the next clk edge.
